// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// holds the returned word for the controller until it is consumed.
module fetch_unit #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [31:0]     instr_count
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [31:0]     count_q, count_d;
  logic            instr_valid_q, instr_valid_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] pc_plus4_w;

  assign pc_plus4_w = pc_q + XLEN'(4);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    unique case (state_q)
      REQ: begin
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Redirect targets are forced word-aligned by dropping the low bits.
        if (!stall) begin
          pc_d    = PCSrc ? {PCTarget[XLEN-1:2], 2'b00} : pc_plus4_w;
          count_d = count_q + 32'd1;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
    instr_valid_d = (state_d == HOLD);
    req_valid_d   = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= REQ;
      pc_q          <= RESET_PC[XLEN-1:0];
      instr_q       <= NOP;
      count_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      req_valid_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      count_q       <= count_d;
      instr_valid_q <= instr_valid_d;
      req_valid_q   <= req_valid_d;
    end
  end

  // The request flop comes out of reset already set, so mask it while reset is held.
  assign imem_req_valid = req_valid_q & reset_n;
  assign imem_addr      = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign op             = instr_q[6:0];
  assign funct3         = instr_q[14:12];
  assign funct7         = instr_q[30];
  assign pc             = pc_q;
  assign pc_plus4       = pc_plus4_w;
  assign instr_count    = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected fetch addresses and
// consumed-instruction records, a monitor pops and compares them as the DUT shows them.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] count;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
  } hold_t;

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr_count;

  logic        mem_en;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        inj_valid;
  logic [31:0] inj_data;
  logic        spacing_chk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  logic [31:0] exp_addr_q[$];
  hold_t       exp_hold_q[$];

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .PCSrc          (pc_src),
    .PCTarget       (pc_target),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .op             (op),
    .funct3         (funct3),
    .funct7         (funct7),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .instr_count    (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  assign imem_rsp_valid = mem_rsp_valid | inj_valid;
  assign imem_rdata     = inj_valid ? inj_data : mem_rdata;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_0104: return 32'h00A0_0113;
      32'h0000_0108: return 32'h0020_81B3;
      32'h0000_010C: return 32'h4030_8233;
      32'h0000_0110: return 32'h0000_006F;
      32'h0000_0200: return 32'h0000_1463;
      32'hFFFF_FFFC: return 32'h0010_0073;
      32'h0000_0000: return 32'h0000_2083;
      default:       return 32'h0000_0033;
    endcase
  endfunction

  // Zero-wait memory: answers in the cycle after it accepts a request.
  always @(posedge clk) begin
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_addr;
    #1;
    mem_rsp_valid = acc && mem_en;
    mem_rdata     = memWord(a);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] w, input logic [31:0] pc4,
                               input logic [31:0] cnt, input logic [6:0] o, input logic [2:0] f3,
                               input logic f7);
    hold_t h;
    h.pc = a; h.instr = w; h.pc4 = pc4; h.count = cnt; h.op = o; h.f3 = f3; h.f7 = f7;
    exp_addr_q.push_back(a);
    exp_hold_q.push_back(h);
  endtask

  task automatic waitHold(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (instr_valid === 1'b1) return;
      step();
    end
    checks++;
    failures++;
    $display("[TB] FAIL wait_hold: got timeout expected instr_valid within %0d cycles", budget);
  endtask

  task automatic waitCount(input logic [31:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (instr_count === target) return;
      step();
    end
    checks++;
    failures++;
    $display("[TB] FAIL wait_count: got %h expected %h within %0d cycles", instr_count, target, budget);
  endtask

  // Monitor: every accepted request and every consumed instruction is scored.
  initial begin
    int last_acc;
    bit have_prev;
    hold_t h;
    have_prev = 0;
    last_acc  = 0;
    forever begin
      @(negedge clk);
      if (reset_n && imem_req_valid && imem_req_ready) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_req: got addr %h expected no request", imem_addr);
        end else begin
          checkOutput("req_addr", imem_addr, exp_addr_q.pop_front());
        end
        if (spacing_chk && have_prev)
          checkOutput("req_spacing", 32'(cycle - last_acc), 32'd3);
        last_acc  = cycle;
        have_prev = 1;
      end
      if (reset_n && instr_valid && !stall) begin
        if (exp_hold_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_hold: got pc %h expected no instruction", pc);
        end else begin
          h = exp_hold_q.pop_front();
          checkOutput("hold_pc", pc, h.pc);
          checkOutput("hold_instr", instr, h.instr);
          checkOutput("hold_pc_plus4", pc_plus4, h.pc4);
          checkOutput("hold_count", instr_count, h.count);
          checkOutput("hold_op", 32'(op), 32'(h.op));
          checkOutput("hold_funct3", 32'(funct3), 32'(h.f3));
          checkOutput("hold_funct7", 32'(funct7), 32'(h.f7));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; imem_req_ready = 1'b1; stall = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
    mem_en = 1'b1; inj_valid = 1'b0; inj_data = 32'h0; spacing_chk = 1'b0;
    mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
    repeat (3) step();

    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instr, 32'h0000_0013);
    checkOutput("rst_op", 32'(op), 32'h13);
    checkOutput("rst_funct3", 32'(funct3), 32'd0);
    checkOutput("rst_funct7", 32'(funct7), 32'd0);
    checkOutput("rst_pc", pc, 32'h100);
    checkOutput("rst_pc_plus4", pc_plus4, 32'h104);
    checkOutput("rst_count", instr_count, 32'd0);

    applyStimulus(32'h100, 32'h0050_0093, 32'h104, 32'd0, 7'h13, 3'd0, 1'b0);
    applyStimulus(32'h104, 32'h00A0_0113, 32'h108, 32'd1, 7'h13, 3'd0, 1'b0);
    applyStimulus(32'h108, 32'h0020_81B3, 32'h10C, 32'd2, 7'h33, 3'd0, 1'b0);
    applyStimulus(32'h10C, 32'h4030_8233, 32'h110, 32'd3, 7'h33, 3'd0, 1'b1);
    spacing_chk = 1'b1;
    reset_n = 1'b1;

    @(negedge clk);
    checkOutput("first_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("first_req_addr", imem_addr, 32'h100);
    @(negedge clk);
    checkOutput("wait_instr_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    checkOutput("hold_instr_valid", 32'(instr_valid), 32'd1);

    waitCount(32'd4, 30);
    checkOutput("seq_count", instr_count, 32'd4);
    spacing_chk = 1'b0;

    // Memory back-pressure: request must stay posted with a stable address.
    imem_req_ready = 1'b0;
    stall = 1'b1;
    applyStimulus(32'h110, 32'h0000_006F, 32'h114, 32'd4, 7'h6F, 3'd0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_req_valid", 32'(imem_req_valid), 32'd1);
      checkOutput("bp_req_addr", imem_addr, 32'h110);
      checkOutput("bp_count", instr_count, 32'd4);
    end
    @(posedge clk);
    #1;
    imem_req_ready = 1'b1;
    waitHold(10);

    repeat (4) begin
      @(negedge clk);
      checkOutput("stall_instr", instr, 32'h0000_006F);
      checkOutput("stall_pc", pc, 32'h110);
      checkOutput("stall_instr_valid", 32'(instr_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    stall = 1'b0; pc_src = 1'b1; pc_target = 32'h203;
    applyStimulus(32'h200, 32'h0000_1463, 32'h204, 32'd5, 7'h63, 3'd1, 1'b0);
    applyStimulus(32'hFFFF_FFFC, 32'h0010_0073, 32'h0, 32'd6, 7'h73, 3'd0, 1'b0);
    exp_addr_q.push_back(32'h0);
    step();
    pc_src = 1'b0;

    waitHold(10);
    pc_src = 1'b1; pc_target = 32'hFFFF_FFFF;
    step();
    pc_src = 1'b0;

    waitHold(10);
    checkOutput("wrap_pc_plus4", pc_plus4, 32'h0);
    mem_en = 1'b0;
    step();
    step();
    checkOutput("wrap_wait_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("wrap_wait_pc", pc, 32'h0);

    // Reset mid-WAIT, then a stale response while back in REQ.
    reset_n = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    checkOutput("midrst_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("midrst_pc", pc, 32'h100);
    step();
    reset_n = 1'b1;
    step();
    inj_valid = 1'b1; inj_data = 32'hDEAD_BEEF;
    step();
    inj_valid = 1'b0;
    @(negedge clk);
    checkOutput("stale_instr", instr, 32'h0000_0013);
    checkOutput("stale_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("stale_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("stale_req_addr", imem_addr, 32'h100);
    checkOutput("stale_count", instr_count, 32'd0);

    applyStimulus(32'h100, 32'h0050_0093, 32'h104, 32'd0, 7'h13, 3'd0, 1'b0);
    mem_en = 1'b1;
    @(posedge clk);
    #1;
    imem_req_ready = 1'b1;
    waitHold(10);
    step();
    imem_req_ready = 1'b0;
    checkOutput("post_rst_count", instr_count, 32'd1);
    checkOutput("post_rst_pc", pc, 32'h104);
    repeat (2) step();

    checkOutput("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    checkOutput("hold_queue_empty", 32'(exp_hold_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
